// File: rtl/reg_file_arb.sv
// Round-robin arbiter/sequencer for the 32x24 dual-port reg_file: one write port
// shared by ALU/load writeback, one 1-cycle sync read port shared by two readers.
// Optional macro RF_BYPASS_EN: forward same-cycle write data to a colliding read.
module reg_file_arb #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rf_wea,
  output logic [ADDR_W-1:0] rf_addra,
  output logic [DATA_W-1:0] rf_dina,
  output logic [ADDR_W-1:0] rf_addrb,
  input  logic [DATA_W-1:0] rf_doutb
);

  // *_last = 1 means source 1 was granted most recently
  logic              wr_last, rd_last;
  logic              rd0_elig, rd1_elig;
  logic [ADDR_W-1:0] addrb_q;
  logic              rd0_vq, rd1_vq;

  always_comb begin
    wr0_gnt  = !rst && wr0_req && (!wr1_req || wr_last);
    wr1_gnt  = !rst && wr1_req && (!wr0_req || !wr_last);
    rf_wea   = wr0_gnt || wr1_gnt;
    rf_addra = wr1_gnt ? wr1_addr : wr0_addr;
    rf_dina  = wr1_gnt ? wr1_data : wr0_data;
  end

`ifdef RF_BYPASS_EN
  logic              byp_sel;
  logic [DATA_W-1:0] byp_data;

  always_comb begin
    rd0_elig = rd0_req;
    rd1_elig = rd1_req;
  end
`else
  // reg_file read-during-write is undefined, so a colliding reader sits out a cycle
  always_comb begin
    rd0_elig = rd0_req && !(rf_wea && (rd0_addr == rf_addra));
    rd1_elig = rd1_req && !(rf_wea && (rd1_addr == rf_addra));
  end
`endif

  always_comb begin
    rd0_gnt  = !rst && rd0_elig && (!rd1_elig || rd_last);
    rd1_gnt  = !rst && rd1_elig && (!rd0_elig || !rd_last);
    rf_addrb = rd1_gnt ? rd1_addr : (rd0_gnt ? rd0_addr : addrb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
      addrb_q <= '0;
      rd0_vq  <= 1'b0;
      rd1_vq  <= 1'b0;
    end else begin
      if (rf_wea) wr_last <= wr1_gnt;
      if (rd0_gnt || rd1_gnt) rd_last <= rd1_gnt;
      addrb_q <= rf_addrb;
      rd0_vq  <= rd0_gnt;
      rd1_vq  <= rd1_gnt;
    end
  end

  assign rd0_valid = rd0_vq && !rst;
  assign rd1_valid = rd1_vq && !rst;

`ifdef RF_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_sel <= (rd0_gnt || rd1_gnt) && rf_wea && (rf_addrb == rf_addra);
      if ((rd0_gnt || rd1_gnt) && rf_wea && (rf_addrb == rf_addra))
        byp_data <= rf_dina;
    end
  end

  assign rd_data = byp_sel ? byp_data : rf_doutb;
`else
  assign rd_data = rf_doutb;
`endif

endmodule

// File: tb/tb_reg_file_arb.sv
// Directed bench for reg_file_arb with a behavioural 32x24 reg_file behind it.
module tb_reg_file_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_req, wr1_req, rd0_req, rd1_req;
  logic [4:0]  wr0_addr, wr1_addr, rd0_addr, rd1_addr;
  logic [23:0] wr0_data, wr1_data;
  logic        wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
  logic [23:0] rd_data;
  logic        rf_wea;
  logic [4:0]  rf_addra, rf_addrb;
  logic [23:0] rf_dina, rf_doutb;
  logic [23:0] mem [32];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ngnt;

  reg_file_arb #(.DATA_W(24), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid),
    .rd_data(rd_data), .rf_wea(rf_wea), .rf_addra(rf_addra), .rf_dina(rf_dina),
    .rf_addrb(rf_addrb), .rf_doutb(rf_doutb)
  );

  always #5 clk = ~clk;

  // reg_file model: sync write on A, 1-cycle sync read on B
  always @(posedge clk) begin
    if (rf_wea) mem[rf_addra] <= rf_dina;
    rf_doutb <= mem[rf_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    wr0_addr = 0; wr1_addr = 0; rd0_addr = 0; rd1_addr = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  // advance to just after the next active edge; inputs are driven here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr0_req = 1; wr1_req = 1; rd0_req = 1; rd1_req = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr0_gnt", 32'(wr0_gnt), 0);
    chk("rst_wr1_gnt", 32'(wr1_gnt), 0);
    chk("rst_rd0_gnt", 32'(rd0_gnt), 0);
    chk("rst_rd1_gnt", 32'(rd1_gnt), 0);
    chk("rst_rf_wea", 32'(rf_wea), 0);
    chk("rst_rf_addrb", 32'(rf_addrb), 0);
    chk("rst_valid", 32'({rd0_valid, rd1_valid}), 0);

    // write contention straight out of reset: wr0 first, then wr1
    cyc(); rst = 0; idle();
    wr0_req = 1; wr0_addr = 3; wr0_data = 24'hAAAAAA;
    wr1_req = 1; wr1_addr = 4; wr1_data = 24'h555555;
    #1;
    chk("wc_n_wr0_gnt", 32'(wr0_gnt), 1);
    chk("wc_n_wr1_gnt", 32'(wr1_gnt), 0);
    chk("wc_n_addra", 32'(rf_addra), 3);
    chk("wc_n_dina", 32'(rf_dina), 32'hAAAAAA);
    cyc(); wr0_req = 0; #1;
    chk("wc_n1_wr1_gnt", 32'(wr1_gnt), 1);
    chk("wc_n1_wr0_gnt", 32'(wr0_gnt), 0);
    chk("wc_n1_addra", 32'(rf_addra), 4);
    cyc(); idle(); rd0_req = 1; rd0_addr = 3; #1;
    chk("wc_rd3_gnt", 32'(rd0_gnt), 1);
    chk("wc_rd3_addrb", 32'(rf_addrb), 3);
    cyc(); rd0_addr = 4; #1;
    chk("wc_rd4_gnt", 32'(rd0_gnt), 1);
    chk("wc_rd3_valid", 32'(rd0_valid), 1);
    chk("wc_rd3_data", 32'(rd_data), 32'hAAAAAA);
    cyc(); idle(); #1;
    chk("wc_rd4_valid", 32'(rd0_valid), 1);
    chk("wc_rd4_data", 32'(rd_data), 32'h555555);

    // fill data=addr, then back-to-back readback
    ngnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(); idle(); wr0_req = 1; wr0_addr = 5'(i); wr0_data = 24'(i); #1;
      if (wr0_gnt) ngnt++;
    end
    chk("fill_gnt_count", 32'(ngnt), 32);
    for (int i = 0; i <= 32; i++) begin
      cyc(); idle();
      if (i < 32) begin rd0_req = 1; rd0_addr = 5'(i); end
      #1;
      if (i < 32) chk("rb_gnt", 32'(rd0_gnt), 1);
      if (i > 0) begin
        chk("rb_valid", 32'(rd0_valid), 1);
        chk("rb_data", 32'(rd_data), 32'(i - 1));
      end
    end

    // single rd1 read leaves rd_last pointing at rd1
    cyc(); idle(); rd1_req = 1; rd1_addr = 5; #1;
    chk("rd1_gnt", 32'(rd1_gnt), 1);
    cyc(); idle(); #1;
    chk("rd1_valid", 32'(rd1_valid), 1);
    chk("rd1_rd0_valid", 32'(rd0_valid), 0);
    chk("rd1_data", 32'(rd_data), 5);

    // read round-robin, plus an unrelated write alongside the first grant
    for (int k = 0; k <= 4; k++) begin
      cyc(); idle();
      if (k < 4) begin rd0_req = 1; rd0_addr = 10; rd1_req = 1; rd1_addr = 20; end
      if (k == 0) begin wr1_req = 1; wr1_addr = 12; wr1_data = 24'hABCDEF; end
      #1;
      if (k == 0) chk("rr_indep_wr1_gnt", 32'(wr1_gnt), 1);
      if (k < 4) begin
        chk("rr_gnt0", 32'(rd0_gnt), 32'(k % 2 == 0));
        chk("rr_gnt1", 32'(rd1_gnt), 32'(k % 2 == 1));
      end
      if (k > 0) begin
        chk("rr_valid0", 32'(rd0_valid), 32'((k - 1) % 2 == 0));
        chk("rr_valid1", 32'(rd1_valid), 32'((k - 1) % 2 == 1));
        chk("rr_data", 32'(rd_data), ((k - 1) % 2 == 0) ? 32'd10 : 32'd20);
      end
    end

    // hazard: addr 7 cleared, then same-cycle write/read of addr 7
    cyc(); idle(); wr0_req = 1; wr0_addr = 7; wr0_data = 0; #1;
    chk("hz_clr_gnt", 32'(wr0_gnt), 1);
    cyc(); idle(); wr0_req = 1; wr0_addr = 7; wr0_data = 24'h123456;
    rd0_req = 1; rd0_addr = 7; #1;
    chk("hz_wr_gnt", 32'(wr0_gnt), 1);
`ifdef RF_BYPASS_EN
    chk("hz_rd_gnt", 32'(rd0_gnt), 1);
    cyc(); idle(); #1;
`else
    chk("hz_rd_masked", 32'(rd0_gnt), 0);
    cyc(); wr0_req = 0; #1;
    chk("hz_rd_gnt_late", 32'(rd0_gnt), 1);
    cyc(); idle(); #1;
`endif
    chk("hz_valid", 32'(rd0_valid), 1);
    chk("hz_data", 32'(rd_data), 32'h123456);

    // reset with an rd1 read in flight
    cyc(); idle(); rd1_req = 1; rd1_addr = 9; #1;
    chk("mr_gnt", 32'(rd1_gnt), 1);
    cyc(); rst = 1; wr0_req = 1; wr1_req = 1; rd0_req = 1; #1;
    chk("mr_rd1_valid", 32'(rd1_valid), 0);
    chk("mr_gnts", 32'({wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt}), 0);
    chk("mr_addrb", 32'(rf_addrb), 0);
    chk("mr_wea", 32'(rf_wea), 0);
    cyc(); rst = 0; idle(); wr0_req = 1; wr0_addr = 1; wr1_req = 1; wr1_addr = 2; #1;
    chk("post_rd1_valid", 32'(rd1_valid), 0);
    chk("post_wr0_gnt", 32'(wr0_gnt), 1);
    chk("post_wr1_gnt", 32'(wr1_gnt), 0);
    cyc(); idle(); #1;
    chk("post_rd1_valid2", 32'(rd1_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_arb.md
Name: reg_file_arb

Overview:
- Arbiter and sequencer for the 32x24 dual-port `reg_file`.
- Shares the single write port (A) between two writeback sources (ALU, load).
- Shares the single synchronous read port (B) between two read clients (decode operand, debug/IO).
- Sits between pipeline stages and `reg_file`; drives `clka/clkb` from the same `clk`, so all timing is in one domain.

Parameters:
- DATA_W, 24, register data width
- ADDR_W, 5, register address width (32 entries)

Ports:
- clk  in  1  system clock; also fed to `reg_file` clka/clkb
- rst  in  1  asynchronous active-high reset
- wr0_req  in  1  write request, source 0 (ALU)
- wr0_addr  in  ADDR_W  write address, source 0
- wr0_data  in  DATA_W  write data, source 0
- wr0_gnt  out  1  write accepted this cycle, source 0
- wr1_req  in  1  write request, source 1 (load)
- wr1_addr  in  ADDR_W  write address, source 1
- wr1_data  in  DATA_W  write data, source 1
- wr1_gnt  out  1  write accepted this cycle, source 1
- rd0_req  in  1  read request, client 0
- rd0_addr  in  ADDR_W  read address, client 0
- rd0_gnt  out  1  read accepted this cycle, client 0
- rd0_valid  out  1  rd_data belongs to client 0 this cycle
- rd1_req  in  1  read request, client 1
- rd1_addr  in  ADDR_W  read address, client 1
- rd1_gnt  out  1  read accepted this cycle, client 1
- rd1_valid  out  1  rd_data belongs to client 1 this cycle
- rd_data  out  DATA_W  read return data
- rf_wea  out  1  to `reg_file` wea
- rf_addra  out  ADDR_W  to `reg_file` addra
- rf_dina  out  DATA_W  to `reg_file` dina
- rf_addrb  out  ADDR_W  to `reg_file` addrb
- rf_doutb  in  DATA_W  from `reg_file` doutb (1-cycle synchronous read)

Behaviour:
- Handshake:
  - Requester holds req/addr/data stable until it sees gnt high in the same cycle; that cycle is the transfer.
  - gnt is combinational from req and state, and is forced 0 while rst is high.
- Write arbitration:
  - At most one write grant per cycle.
  - Only one requester: it wins.
  - Both requesting: winner is the source not granted last, tracked by 1-bit `wr_last` register.
  - `wr_last` updates only on a grant; reset value 1, so source 0 wins the first tie.
  - rf_wea = wr0_gnt | wr1_gnt. rf_addra/rf_dina are muxed from the winner, and driven from source 0 when idle.
- Read arbitration:
  - Same round-robin scheme, with its own `rd_last` register (reset 1).
  - rf_addrb = winner's address; holds its previous registered value when no read is granted (reset 0).
- Read return:
  - Latency exactly 1 cycle: rdN_valid pulses the cycle after rdN_gnt.
  - rd_data is valid only while rd0_valid or rd1_valid is high.
  - Back-to-back grants give back-to-back valids. rd0_valid and rd1_valid are never high together.
- Outputs during reset:
  - rd0_valid/rd1_valid = 0.
  - rf_addrb = 0.
  - All gnt outputs = 0; rf_wea = 0.
- Reset mid-operation: any in-flight read is dropped (no valid issued after reset deasserts).
- Same-cycle read/write to the same address: `reg_file` read-during-write is undefined, so this case is resolved by RF_BYPASS_EN (see below).
- Reads and writes to different addresses in the same cycle proceed independently.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined:
  - A granted read whose address equals the granted write address in that cycle is still granted.
  - The write data is captured in a register; next cycle rd_data returns the captured write data instead of rf_doutb.
  - Reads never stall on a hazard.
- Undefined:
  - A read requester whose address equals the granted write address that cycle is masked from read arbitration (no gnt).
  - The other read requester may be granted if it has no conflict.
  - `rd_last` does not change unless a grant occurs.
  - rd_data = rf_doutb directly.

Test Plan:
- Fill and readback: wr0 writes data=addr for addr 0..31 in consecutive cycles; then rd0 reads 0..31 back-to-back. Required: 32 wr0_gnt pulses; rd0_valid for 32 consecutive cycles with rd_data = 0..31.
- Write contention: wr0 (addr 3, 0xAAAAAA) and wr1 (addr 4, 0x555555) request together from reset. Required: wr0_gnt cycle n, wr1_gnt cycle n+1; subsequent reads of addr 3 and 4 return 0xAAAAAA and 0x555555.
- Read round-robin: rd0 and rd1 both hold req for 4 cycles. Required: grants alternate rd0, rd1, rd0, rd1; valids follow 1 cycle later in the same order.
- Hazard: write 0x123456 to addr 7 while rd0 reads addr 7, same cycle, addr 7 previously 0.
  - With RF_BYPASS_EN: rd0_gnt same cycle, rd_data = 0x123456 next cycle.
  - Without: rd0_gnt delayed one cycle, then rd_data = 0x123456.
- Reset mid-read: assert rst in the cycle after rd1_gnt. Required: rd1_valid stays 0, all gnt = 0, rf_addrb = 0. After release, a tie between wr0 and wr1 is won by wr0.
